// File: rtl/tcm_pkg.sv
// Shared definitions for the 4-state rate-2/3 TCM encoder and the matching decoder models.
package tcm_pkg;

    localparam int DATA_W   = 2;
    localparam int SYM_W    = 3;
    localparam int STATE_W  = 2;
    localparam int TAIL_LEN = 2;

    typedef enum logic [1:0] {
        RUN,
        TAIL1,
        TAIL2
    } fsm_state_t;

    typedef struct packed {
        logic [SYM_W-1:0]   y;
        logic [STATE_W-1:0] s_next;
    } enc_result_t;

    // x = {x2, x1}, s = {s1, s0}; x2 passes uncoded, x1 drives the convolutional part.
    function automatic enc_result_t tcm_encode(input logic [DATA_W-1:0] x,
                                               input logic [STATE_W-1:0] s);
        enc_result_t r;
        r.y      = {x[1], x[0], s[0]};
        r.s_next = {s[0], s[1] ^ x[0]};
        return r;
    endfunction

endpackage

// File: rtl/tcm_encoder_if.sv
// Data-in and symbol-out handshakes of the TCM encoder bundled as one port.
interface tcm_encoder_if;
    import tcm_pkg::*;

    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic [SYM_W-1:0]  sym;
    logic              sym_valid;
    logic              sym_last;
    logic              sym_ready;
    logic              ovf;

    modport master (
        output in_data, in_valid, in_last, sym_ready,
        input  in_ready, sym, sym_valid, sym_last, ovf
    );

    modport slave (
        input  in_data, in_valid, in_last, sym_ready,
        output in_ready, sym, sym_valid, sym_last, ovf
    );

endinterface

// File: rtl/tcm_out_reg.sv
// Single-entry valid/ready output register carrying {sym, sym_last}.
module tcm_out_reg
    import tcm_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             src_valid,
    input  logic [SYM_W-1:0] src_sym,
    input  logic             src_last,
    output logic             src_ready,
    output logic             load,
    output logic [SYM_W-1:0] sym,
    output logic             sym_valid,
    output logic             sym_last,
    input  logic             sym_ready
);

    assign src_ready = !sym_valid || sym_ready;
    assign load      = src_valid && src_ready;

    // Data only changes on a load, so a stalled symbol stays put.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sym       <= '0;
            sym_valid <= 1'b0;
            sym_last  <= 1'b0;
        end else if (load) begin
            sym       <= src_sym;
            sym_last  <= src_last;
            sym_valid <= 1'b1;
        end else if (sym_ready) begin
            sym_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/tcm_encoder.sv
// Rate-2/3 4-state TCM encoder for 8-PSK: encodes framed 2-bit words and appends two tail symbols.
module tcm_encoder
    import tcm_pkg::*;
#(
    parameter int MAX_FRAME = 255
)
(
    input  logic          clk,
    input  logic          reset,
    tcm_encoder_if.slave  bus
);

    localparam logic [7:0] LAST_IDX = 8'(MAX_FRAME - 1);

    fsm_state_t         state;
    fsm_state_t         state_next;
    logic [STATE_W-1:0] s;
    logic [7:0]         frame_cnt;
    logic               ovf_q;

    logic               in_run;
    logic               src_valid;
    logic               src_ready;
    logic               load;
    logic               accept;
    logic               at_limit;
    logic               frame_end;
    logic [DATA_W-1:0]  x;
    enc_result_t        enc;

    assign in_run       = (state == RUN);
    assign src_valid    = in_run ? bus.in_valid : 1'b1;
    assign bus.in_ready = in_run && src_ready;
    assign accept       = bus.in_valid && bus.in_ready;
    assign at_limit     = (frame_cnt == LAST_IDX);
    assign frame_end    = bus.in_last || at_limit;
    // Tail symbols feed x1 = s1 so two of them flush the trellis back to state 0.
    assign x            = in_run ? bus.in_data : {1'b0, s[1]};
    assign enc          = tcm_encode(x, s);
    assign bus.ovf      = ovf_q;

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (accept && frame_end) state_next = TAIL1;
            TAIL1:   if (load) state_next = TAIL2;
            TAIL2:   if (load) state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= RUN;
            s         <= '0;
            frame_cnt <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state <= state_next;
            ovf_q <= accept && at_limit && !bus.in_last;
            if (load) begin
                s <= enc.s_next;
            end
            if (accept) begin
                frame_cnt <= frame_end ? 8'd0 : frame_cnt + 8'd1;
            end
        end
    end

    tcm_out_reg u_out_reg (
        .clk       (clk),
        .reset     (reset),
        .src_valid (src_valid),
        .src_sym   (enc.y),
        .src_last  (state == TAIL2),
        .src_ready (src_ready),
        .load      (load),
        .sym       (bus.sym),
        .sym_valid (bus.sym_valid),
        .sym_last  (bus.sym_last),
        .sym_ready (bus.sym_ready)
    );

endmodule
